// File: rtl/obi_mon_pkg.sv
// Shared types and helpers for the OBI data-port protocol monitor.
// Provides the error-bit index map, the stored transaction record, the
// request-FSM state encoding and two small combinational helpers.
package obi_mon_pkg;

    // Widths of the stored transaction record. The monitor's ADDR_W/DATA_W
    // parameters must not exceed these; narrower buses are zero-extended.
    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = OBI_DATA_W / 8;

    localparam int ERR_W = 7;

    typedef enum logic [2:0] {
        ERR_REQ_DROP     = 3'd0,
        ERR_REQ_UNSTABLE = 3'd1,
        ERR_GNT_TMO      = 3'd2,
        ERR_RVLD_ORPHAN  = 3'd3,
        ERR_OUTST_OVF    = 3'd4,
        ERR_BE_ILLEGAL   = 3'd5,
        ERR_RVLD_TMO     = 3'd6
    } err_idx_e;

    typedef enum logic [0:0] {
        REQ_IDLE = 1'b0,
        REQ_WAIT = 1'b1
    } req_state_e;

    typedef struct packed {
        logic [OBI_ADDR_W-1:0] addr;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_DATA_W-1:0] wdata;
    } txn_t;

    // Byte enables are legal when non-zero and forming one contiguous run.
    function automatic logic be_legal(input logic [OBI_BE_W-1:0] be);
        logic [3:0] runs;
        logic       prev;
        runs = 4'd0;
        prev = 1'b0;
        for (int i = 0; i < OBI_BE_W; i++) begin
            if (be[i] && !prev) begin
                runs = runs + 4'd1;
            end else begin
                runs = runs;
            end
            prev = be[i];
        end
        return (runs == 4'd1);
    endfunction

    // A waiting request must keep its attributes; wdata only matters for writes.
    function automatic logic txn_differs(input txn_t held, input txn_t cur);
        return (held.addr != cur.addr) || (held.we != cur.we) || (held.be != cur.be) ||
               (cur.we && (held.wdata != cur.wdata));
    endfunction

endpackage

// File: rtl/obi_txn_fifo.sv
// In-order circular buffer of outstanding OBI transactions.
// Ports: clk/rst (async active-high), push/wdata enqueue, pop dequeues the
// head, head shows the oldest entry, count/full/empty report occupancy.
// A push while full is accepted only when a pop happens in the same cycle.
module obi_txn_fifo
    import obi_mon_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  txn_t             wdata,
    input  logic             pop,
    output txn_t             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    txn_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == '0);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Entry storage; payload only, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Wrapping pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/obi_data_protocol_monitor.sv
// Passive protocol monitor for the core's OBI data port (req/gnt/rvalid).
// Inputs: the full request/response bus plus err_clr. Outputs:
//   err_pulse  - violations detected in the previous cycle (registered, 1 cycle)
//   err_sticky - accumulated violations, cleared by err_clr (clear wins)
//   outst_cnt  - granted transactions still awaiting rvalid
//   cmp_*      - completed transaction, strobed the cycle after its rvalid
//   rd_cnt/wr_cnt - saturating completion counters
// Error bits: 0 req drop, 1 req unstable, 2 gnt timeout, 3 orphan rvalid,
// 4 outstanding overflow, 5 illegal be, 6 rvalid timeout.
module obi_data_protocol_monitor
    import obi_mon_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2,
    parameter int GNT_TMO   = 16,
    parameter int RVLD_TMO  = 32,
    parameter int CNT_W     = 32,
    localparam int BE_W     = DATA_W / 8,
    localparam int OC_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_req_o,
    input  logic              data_gnt_i,
    input  logic [ADDR_W-1:0] data_addr_o,
    input  logic              data_we_o,
    input  logic [BE_W-1:0]   data_be_o,
    input  logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    input  logic              err_clr,
    output logic [ERR_W-1:0]  err_sticky,
    output logic [ERR_W-1:0]  err_pulse,
    output logic [OC_W-1:0]   outst_cnt,
    output logic              cmp_valid,
    output logic [ADDR_W-1:0] cmp_addr,
    output logic              cmp_we,
    output logic [BE_W-1:0]   cmp_be,
    output logic [DATA_W-1:0] cmp_data,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    // Counters run one past their limit so the limit is hit exactly once.
    localparam int WC_W = $clog2(GNT_TMO + 2);
    localparam int AC_W = $clog2(RVLD_TMO + 2);

    txn_t             req_txn_s;
    txn_t             head_s;
    txn_t             hold_r;
    txn_t             hold_nxt_s;
    req_state_e       state_r;
    req_state_e       state_nxt_s;
    logic [WC_W-1:0]  wait_cnt_r;
    logic [WC_W-1:0]  cur_wait_s;
    logic [AC_W-1:0]  age_r;
    logic [AC_W-1:0]  cur_age_s;
    logic [OC_W-1:0]  fifo_cnt_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             accept_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             unstable_s;
    logic [ERR_W-1:0] err_det_s;

    logic [ERR_W-1:0]  err_sticky_r;
    logic [ERR_W-1:0]  err_pulse_r;
    logic              cmp_valid_r;
    logic [ADDR_W-1:0] cmp_addr_r;
    logic              cmp_we_r;
    logic [BE_W-1:0]   cmp_be_r;
    logic [DATA_W-1:0] cmp_data_r;
    logic [CNT_W-1:0]  rd_cnt_r;
    logic [CNT_W-1:0]  wr_cnt_r;

    assign req_txn_s.addr  = OBI_ADDR_W'(data_addr_o);
    assign req_txn_s.we    = data_we_o;
    assign req_txn_s.be    = OBI_BE_W'(data_be_o);
    assign req_txn_s.wdata = OBI_DATA_W'(data_wdata_o);

    assign accept_s = data_req_o & data_gnt_i;
    // rvalid is matched only against entries granted in earlier cycles.
    assign pop_s    = data_rvalid_i & ~fifo_empty_s;
    assign push_s   = accept_s & (~fifo_full_s | pop_s);

    obi_txn_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (req_txn_s),
        .pop   (pop_s),
        .head  (head_s),
        .count (fifo_cnt_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Request FSM next state, hold capture and wait-cycle counting.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        cur_wait_s  = '0;
        drop_s      = 1'b0;
        unstable_s  = 1'b0;
        case (state_r)
            REQ_IDLE: begin
                if (data_req_o && !data_gnt_i) begin
                    state_nxt_s = REQ_WAIT;
                    hold_nxt_s  = req_txn_s;
                    cur_wait_s  = WC_W'(1);
                end else begin
                    state_nxt_s = REQ_IDLE;
                end
            end
            REQ_WAIT: begin
                if (!data_req_o) begin
                    drop_s      = 1'b1;
                    state_nxt_s = REQ_IDLE;
                end else begin
                    unstable_s = txn_differs(hold_r, req_txn_s);
                    if (data_gnt_i) begin
                        state_nxt_s = REQ_IDLE;
                    end else begin
                        cur_wait_s = wait_cnt_r + WC_W'(1);
                    end
                end
            end
            default: begin
                state_nxt_s = REQ_IDLE;
            end
        endcase
    end

    // Age of the head entry; cleared by a pop or an empty queue.
    always_comb begin
        if (pop_s || fifo_empty_s) begin
            cur_age_s = '0;
        end else begin
            cur_age_s = age_r + AC_W'(1);
        end
    end

    // Violations detected in the current cycle.
    always_comb begin
        err_det_s                   = '0;
        err_det_s[ERR_REQ_DROP]     = drop_s;
        err_det_s[ERR_REQ_UNSTABLE] = unstable_s;
        err_det_s[ERR_GNT_TMO]      = (cur_wait_s == WC_W'(GNT_TMO));
        err_det_s[ERR_RVLD_ORPHAN]  = data_rvalid_i & fifo_empty_s;
        err_det_s[ERR_OUTST_OVF]    = accept_s & fifo_full_s & ~pop_s;
        err_det_s[ERR_BE_ILLEGAL]   = data_req_o & ~be_legal(OBI_BE_W'(data_be_o));
        err_det_s[ERR_RVLD_TMO]     = (cur_age_s == AC_W'(RVLD_TMO));
    end

    // FSM state, hold register and saturating timers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= REQ_IDLE;
            hold_r     <= '0;
            wait_cnt_r <= '0;
            age_r      <= '0;
        end else begin
            state_r    <= state_nxt_s;
            hold_r     <= hold_nxt_s;
            wait_cnt_r <= (cur_wait_s > WC_W'(GNT_TMO)) ? WC_W'(GNT_TMO) : cur_wait_s;
            age_r      <= (cur_age_s > AC_W'(RVLD_TMO)) ? AC_W'(RVLD_TMO) : cur_age_s;
        end
    end

    // Error pulse and sticky vectors; a clear beats a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse_r  <= '0;
            err_sticky_r <= '0;
        end else begin
            err_pulse_r  <= err_det_s;
            err_sticky_r <= err_clr ? '0 : (err_sticky_r | err_det_s);
        end
    end

    // Completion record and saturating read/write counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid_r <= 1'b0;
            cmp_addr_r  <= '0;
            cmp_we_r    <= 1'b0;
            cmp_be_r    <= '0;
            cmp_data_r  <= '0;
            rd_cnt_r    <= '0;
            wr_cnt_r    <= '0;
        end else begin
            cmp_valid_r <= pop_s;
            if (pop_s) begin
                cmp_addr_r <= head_s.addr[ADDR_W-1:0];
                cmp_we_r   <= head_s.we;
                cmp_be_r   <= head_s.be[BE_W-1:0];
                cmp_data_r <= head_s.we ? head_s.wdata[DATA_W-1:0] : data_rdata_i;
                if (head_s.we && (wr_cnt_r != '1)) begin
                    wr_cnt_r <= wr_cnt_r + CNT_W'(1);
                end else if (!head_s.we && (rd_cnt_r != '1)) begin
                    rd_cnt_r <= rd_cnt_r + CNT_W'(1);
                end else begin
                    wr_cnt_r <= wr_cnt_r;
                end
            end
        end
    end

    assign err_sticky = err_sticky_r;
    assign err_pulse  = err_pulse_r;
    assign outst_cnt  = fifo_cnt_s;
    assign cmp_valid  = cmp_valid_r;
    assign cmp_addr   = cmp_addr_r;
    assign cmp_we     = cmp_we_r;
    assign cmp_be     = cmp_be_r;
    assign cmp_data   = cmp_data_r;
    assign rd_cnt     = rd_cnt_r;
    assign wr_cnt     = wr_cnt_r;

endmodule

// File: tb/tb_obi_data_protocol_monitor.sv
// Self-checking bench for obi_data_protocol_monitor: directed scenarios
// followed by randomized bus traffic, all compared against a transaction-level
// reference model (queue of outstanding requests, plain integer timers).
module tb_obi_data_protocol_monitor;

    localparam int MAX_OUTST = 2;
    localparam int GNT_TMO   = 16;
    localparam int RVLD_TMO  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, gnt = 1'b0, we = 1'b0, rvalid = 1'b0, clr = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata = '0;
    logic [3:0]  be = '0;
    logic [6:0]  err_sticky, err_pulse;
    logic [1:0]  outst_cnt;
    logic        cmp_valid, cmp_we;
    logic [31:0] cmp_addr, cmp_data, rd_cnt, wr_cnt;
    logic [3:0]  cmp_be;

    int n_cmp = 0;
    int n_mis = 0;

    obi_data_protocol_monitor #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTST(MAX_OUTST),
        .GNT_TMO(GNT_TMO), .RVLD_TMO(RVLD_TMO), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .data_req_o(req), .data_gnt_i(gnt), .data_addr_o(addr), .data_we_o(we),
        .data_be_o(be), .data_wdata_o(wdata), .data_rvalid_i(rvalid), .data_rdata_i(rdata),
        .err_clr(clr), .err_sticky(err_sticky), .err_pulse(err_pulse), .outst_cnt(outst_cnt),
        .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_we(cmp_we), .cmp_be(cmp_be),
        .cmp_data(cmp_data), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mtxn_t;

    mtxn_t       mq[$];
    mtxn_t       m_hold;
    bit          m_waiting;
    int          m_wait_len, m_age, m_rd, m_wr;
    logic [6:0]  m_sticky, m_pulse;
    bit          e_valid;
    mtxn_t       e_txn;
    logic [31:0] e_data;

    function automatic bit m_be_ok(input logic [3:0] b);
        int v;
        if (b == 4'd0) return 1'b0;
        v = int'(b);
        while (v % 2 == 0) v = v / 2;
        return ((v & (v + 1)) == 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_waiting = 1'b0; m_wait_len = 0; m_age = 0; m_rd = 0; m_wr = 0;
        m_sticky = '0; m_pulse = '0; e_valid = 1'b0;
    endtask

    task automatic model_cycle();
        logic [6:0] det;
        int  size0;
        bit  pop;
        mtxn_t cur;
        det = '0;
        cur.addr = addr; cur.we = we; cur.be = be; cur.wdata = wdata;
        size0 = mq.size();
        if (req && !m_be_ok(be)) det[5] = 1'b1;
        if (m_waiting && !req) det[0] = 1'b1;
        if (m_waiting && req &&
            (cur.addr != m_hold.addr || cur.we != m_hold.we || cur.be != m_hold.be ||
             (cur.we && cur.wdata != m_hold.wdata))) det[1] = 1'b1;
        if (req && !gnt) begin
            if (!m_waiting) m_hold = cur;
            m_wait_len = m_waiting ? m_wait_len + 1 : 1;
            m_waiting = 1'b1;
            if (m_wait_len == GNT_TMO) det[2] = 1'b1;
        end else begin
            m_waiting = 1'b0;
            m_wait_len = 0;
        end
        pop = rvalid && (size0 > 0);
        if (rvalid && size0 == 0) det[3] = 1'b1;
        if (req && gnt && size0 == MAX_OUTST && !pop) det[4] = 1'b1;
        if (size0 > 0 && !pop) begin
            m_age++;
            if (m_age == RVLD_TMO) det[6] = 1'b1;
        end else begin
            m_age = 0;
        end
        e_valid = pop;
        if (pop) begin
            e_txn = mq.pop_front();
            e_data = e_txn.we ? e_txn.wdata : rdata;
            if (e_txn.we) m_wr++; else m_rd++;
        end
        if (req && gnt && mq.size() < MAX_OUTST) mq.push_back(cur);
        m_pulse = det;
        m_sticky = clr ? 7'd0 : (m_sticky | det);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        chk("outst_cnt", 64'(outst_cnt), 64'(mq.size()));
        chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
        chk("cmp_valid", 64'(cmp_valid), 64'(e_valid));
        chk("rd_cnt", 64'(rd_cnt), 64'(m_rd));
        chk("wr_cnt", 64'(wr_cnt), 64'(m_wr));
        if (e_valid) begin
            chk("cmp_addr", 64'(cmp_addr), 64'(e_txn.addr));
            chk("cmp_we", 64'(cmp_we), 64'(e_txn.we));
            chk("cmp_be", 64'(cmp_be), 64'(e_txn.be));
            chk("cmp_data", 64'(cmp_data), 64'(e_data));
        end
    endtask

    task automatic drv(input logic r, input logic g, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] wd, input logic rv,
                       input logic [31:0] rd);
        req = r; gnt = g; addr = a; we = w; be = b; wdata = wd; rvalid = rv; rdata = rd;
        clr = 1'b0;
        step();
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outst"}, 64'(outst_cnt), 64'd0);
        chk({tag, "_sticky"}, 64'(err_sticky), 64'd0);
        chk({tag, "_pulse"}, 64'(err_pulse), 64'd0);
        chk({tag, "_cmpv"}, 64'(cmp_valid), 64'd0);
        chk({tag, "_cmpa"}, 64'(cmp_addr), 64'd0);
        chk({tag, "_cmpd"}, 64'(cmp_data), 64'd0);
        chk({tag, "_cnt"}, 64'(rd_cnt | wr_cnt), 64'd0);
    endtask

    logic [3:0] legal_be [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'h7, 4'hE, 4'hF};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // 1: single read
        drv(1'b1, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF);
        chk("t1_valid", 64'(cmp_valid), 64'd1);
        chk("t1_addr", 64'(cmp_addr), 64'h100);
        chk("t1_data", 64'(cmp_data), 64'hDEADBEEF);
        chk("t1_rdcnt", 64'(rd_cnt), 64'd1);
        chk("t1_sticky", 64'(err_sticky), 64'd0);
        idle();

        // 2: back-to-back writes, overflow attempt, in-order completion
        drv(1'b1, 1'b1, 32'h0, 1'b1, 4'hF, 32'h11111111, 1'b0, 32'h0);
        chk("t2_o1", 64'(outst_cnt), 64'd1);
        drv(1'b1, 1'b1, 32'h4, 1'b1, 4'hF, 32'h22222222, 1'b0, 32'h0);
        chk("t2_o2", 64'(outst_cnt), 64'd2);
        drv(1'b1, 1'b1, 32'h8, 1'b1, 4'hF, 32'h33333333, 1'b0, 32'h0);
        chk("t2_ovf", 64'(err_pulse[4]), 64'd1);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
        chk("t2_o3", 64'(outst_cnt), 64'd1);
        chk("t2_a0", 64'(cmp_addr), 64'h0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
        chk("t2_o4", 64'(outst_cnt), 64'd0);
        chk("t2_a4", 64'(cmp_addr), 64'h4);
        chk("t2_wdata", 64'(cmp_data), 64'h22222222);
        chk("t2_wrcnt", 64'(wr_cnt), 64'd2);
        idle();

        // 3: unstable request, dropped request, grant timeout
        drv(1'b1, 1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
        drv(1'b1, 1'b0, 32'h14, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
        chk("t3_unstable", 64'(err_pulse[1]), 64'd1);
        drv(1'b0, 1'b0, 32'h14, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
        chk("t3_drop", 64'(err_pulse[0]), 64'd1);
        for (int i = 1; i <= GNT_TMO + 3; i++) begin
            drv(1'b1, 1'b0, 32'h20, 1'b0, 4'h3, 32'h0, 1'b0, 32'h0);
            if (i == GNT_TMO - 1) chk("t3_tmo_early", 64'(err_pulse[2]), 64'd0);
            if (i == GNT_TMO) chk("t3_tmo", 64'(err_pulse[2]), 64'd1);
            if (i == GNT_TMO + 2) chk("t3_tmo_once", 64'(err_pulse[2]), 64'd0);
        end
        drv(1'b1, 1'b1, 32'h20, 1'b0, 4'h3, 32'h0, 1'b0, 32'h0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h5A5A5A5A);

        // 4: orphan rvalid, illegal byte enables, sticky clear
        drv(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
        chk("t4_orphan", 64'(err_pulse[3]), 64'd1);
        chk("t4_nocmp", 64'(cmp_valid), 64'd0);
        drv(1'b1, 1'b1, 32'h30, 1'b0, 4'h5, 32'h0, 1'b0, 32'h0);
        chk("t4_be", 64'(err_pulse[5]), 64'd1);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0);
        req = 1'b0; gnt = 1'b0; rvalid = 1'b0; clr = 1'b1;
        step();
        chk("t4_clr", 64'(err_sticky), 64'd0);
        idle();

        // 5: rvalid timeout, then reset mid-wait
        drv(1'b1, 1'b1, 32'h200, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
        for (int i = 1; i <= RVLD_TMO + 2; i++) begin
            idle();
            if (i == RVLD_TMO - 1) chk("t5_tmo_early", 64'(err_pulse[6]), 64'd0);
            if (i == RVLD_TMO) chk("t5_tmo", 64'(err_pulse[6]), 64'd1);
        end
        rst = 1'b1;
        #1;
        chk_all_zero("t5_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) idle();
        chk("t5_noerr", 64'(err_sticky), 64'd0);

        // 6: full queue with simultaneous grant and rvalid across pointer wrap
        drv(1'b1, 1'b1, 32'h1000, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);
        drv(1'b1, 1'b1, 32'h1004, 1'b1, 4'hC, 32'hCAFE0001, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            drv(1'b1, 1'b1, 32'h2000 + 32'(4 * k), k[0], 4'hF, 32'hB0000000 + 32'(k),
                1'b1, 32'hA0000000 + 32'(k));
            chk("t6_noovf", 64'(err_pulse[4]), 64'd0);
            chk("t6_full", 64'(outst_cnt), 64'd2);
            if (k == 0) chk("t6_first", 64'(cmp_addr), 64'h1000);
        end
        drv(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h77);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h88);
        chk("t6_drained", 64'(outst_cnt), 64'd0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (m_waiting && $urandom_range(0, 9) != 0) begin
                req = 1'b1;
            end else begin
                req   = ($urandom_range(0, 9) < 6);
                addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                we    = 1'($urandom_range(0, 1));
                be    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                    : legal_be[$urandom_range(0, 9)];
                wdata = $urandom;
            end
            gnt    = ($urandom_range(0, 9) < 5);
            rvalid = ($urandom_range(0, 9) < 4);
            rdata  = $urandom;
            clr    = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
